usb_packet_tx: RTL and testbench
================================

Name: usb_packet_tx

Overview:
- SIE-side packet sender that drives the byte-level TX interface of usb_transceiver (tx_data/tx_valid/tx_ready).
- Builds low-speed device packets:
  - handshake = PID byte only;
  - data = PID byte + 0..MAX_LEN payload bytes + CRC16.
- Sits between the device endpoint logic, which supplies PID, length and a payload stream, and the transceiver, which adds SYNC, NRZI, bit-stuffing and EOP.

Parameters:
MAX_LEN, 8, maximum payload bytes per data packet (low-speed limit)
TIMEOUT_CYCLES, 1024, clk cycles to wait for tx_ready before abort (used only with USB_PKT_TX_TIMEOUT_EN)

Ports:
clk  input  1  system clock, 24 MHz
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to send a packet; sampled only when busy=0
pid  input  4  packet PID; pid[1:0]==2'b11 means data packet, anything else means handshake
len  input  $clog2(MAX_LEN+1)  payload byte count, sampled with start, ignored for handshakes
pl_data  input  8  payload byte
pl_valid  input  1  pl_data valid
pl_ready  output  1  single-cycle pulse: pl_data consumed this cycle
tx_data  output  8  byte to transceiver
tx_valid  output  1  rise starts SYNC; high while sending; fall produces EOP
tx_ready  input  1  single-cycle pulse from transceiver: current tx_data has been taken
busy  output  1  packet in progress
done  output  1  single-cycle pulse: packet finished normally
error  output  1  single-cycle pulse: request rejected or packet aborted

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; tx_valid=0, tx_data=8'h00, pl_ready=0, busy=0, done=0, error=0, CRC register=16'hFFFF.
- States: IDLE, PID, DATA, CRC_LO, CRC_HI.
- IDLE:
  - On start with a data PID and len>MAX_LEN: error pulse next cycle, stay IDLE, tx_valid stays 0.
  - Otherwise, start at cycle n gives the following at cycle n+1: tx_data={~pid,pid}, tx_valid=1, busy=1, CRC=16'hFFFF. Next state is PID.
- start while busy=1 is ignored, with no error.
- Every non-IDLE state holds tx_data stable until tx_ready.
- On tx_ready at cycle m, the next byte appears at m+1, transitions as follows:
  - PID, handshake: tx_valid=0 at m+1, done pulse at m+1, go to IDLE.
  - PID, data, len==0: tx_data = low byte of ~CRC, go to CRC_LO.
  - PID, data, len>0: requires pl_valid=1 at cycle m.
    - pl_ready pulses at m.
    - tx_data=pl_data at m+1.
    - CRC updated with that byte (8 bits in one cycle).
    - Remaining count = len-1; go to DATA.
  - DATA, remaining>0: same payload fetch as above, remaining decremented.
  - DATA, remaining==0: tx_data=~CRC[7:0], go to CRC_LO.
  - CRC_LO: tx_data=~CRC[15:8], go to CRC_HI.
  - CRC_HI: tx_valid=0 and done at m+1, go to IDLE.
- CRC16: polynomial 0x8005, reflected (LSB-first) form 0xA001, init 0xFFFF, bytes processed LSB first, transmitted complemented, low byte first.
- Underrun: pl_valid=0 at a cycle where a payload byte is needed.
  - pl_ready stays 0.
  - tx_valid=0, error pulse and busy=0 at m+1; go to IDLE.
  - No done.
- tx_ready while IDLE: ignored.
- done and error never assert in the same cycle.
- busy falls in the same cycle done or error pulses.
- The next start is accepted in that same cycle.

Optional Feature:
- Macro USB_PKT_TX_TIMEOUT_EN.
- With the macro defined:
  - A counter resets at every byte presentation.
  - If TIMEOUT_CYCLES clocks pass in a non-IDLE state without tx_ready, the block aborts: tx_valid=0, error pulse, go to IDLE.
- Without the macro: no counter; the block waits for tx_ready indefinitely.

Test Plan:
- ACK: start, pid=4'h2 → tx_data=8'hD2 with tx_valid=1 the next cycle; after one tx_ready, tx_valid=0 and a done pulse; pl_ready never asserts.
- Zero-length DATA0: pid=4'h3, len=0 → bytes C3, 00, 00 on successive tx_ready pulses; then tx_valid=0 and done.
- DATA1 with len=4, payload 00 01 02 03 held valid → bytes 4B, 00, 01, 02, 03, CRC_lo, CRC_hi.
  - CRC bytes match the bench reference model.
  - Exactly 4 pl_ready pulses.
- Underrun: DATA0, len=3, pl_valid dropped before the 2nd payload byte → tx_valid=0 and an error pulse the cycle after that tx_ready; no done; next start accepted.
- Rejects and reset:
  - len=9 with pid=4'h3 → error pulse, tx_valid stays 0.
  - reset=0 asserted mid-DATA → tx_valid=0 and busy=0 immediately (asynchronous).
- With USB_PKT_TX_TIMEOUT_EN and TIMEOUT_CYCLES=1024: tx_ready withheld after the PID byte → error pulse, tx_valid=0.

Source files
------------

// File: rtl/usb_packet_tx.sv
`default_nettype none
// ============================================================================
// usb_packet_tx : low-speed USB packet sender (PID, payload, CRC16) feeding
//                 the transceiver byte interface. Optional: USB_PKT_TX_TIMEOUT_EN
// Revision 1.0  : initial release
// ============================================================================
module usb_packet_tx #(
    parameter int MAX_LEN        = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [3:0]                   pid,
    input  logic [$clog2(MAX_LEN+1)-1:0] len,
    input  logic [7:0]                   pl_data,
    input  logic                         pl_valid,
    output logic                         pl_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam int              LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PID    = 3'd1,
        S_DATA   = 3'd2,
        S_CRC_LO = 3'd3,
        S_CRC_HI = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [15:0]      crc_q, crc_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             is_data_q, is_data_d;
    logic             finish;
    logic             abort;
    logic             start_is_data;

    // Reflected CRC16 (0xA001), one whole byte per clock, LSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign start_is_data = (pid[1:0] == 2'b11);

`ifdef USB_PKT_TX_TIMEOUT_EN
    localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]           to_q, to_d;
`endif

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        crc_d      = crc_q;
        rem_d      = rem_q;
        is_data_d  = is_data_q;
        pl_ready   = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_is_data && (len > MAX_LEN_L)) begin
                        error_d = 1'b1;
                    end else begin
                        tx_data_d  = {~pid, pid};
                        tx_valid_d = 1'b1;
                        busy_d     = 1'b1;
                        crc_d      = 16'hFFFF;
                        rem_d      = start_is_data ? len : '0;
                        is_data_d  = start_is_data;
                        state_d    = S_PID;
                    end
                end
            end
            // PID and DATA share the payload fetch; rem_q counts bytes still owed
            S_PID, S_DATA: begin
                if (tx_ready) begin
                    if (!is_data_q) begin
                        finish = 1'b1;
                    end else if (rem_q == '0) begin
                        tx_data_d = ~crc_q[7:0];
                        state_d   = S_CRC_LO;
                    end else if (pl_valid) begin
                        pl_ready  = 1'b1;
                        tx_data_d = pl_data;
                        crc_d     = crc16_byte(crc_q, pl_data);
                        rem_d     = rem_q - LEN_W'(1);
                        state_d   = S_DATA;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            S_CRC_LO: begin
                if (tx_ready) begin
                    tx_data_d = ~crc_q[15:8];
                    state_d   = S_CRC_HI;
                end
            end
            S_CRC_HI: begin
                if (tx_ready) begin
                    finish = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef USB_PKT_TX_TIMEOUT_EN
        to_d = '0;
        if ((state_q != S_IDLE) && !tx_ready) begin
            if (to_q == TO_LAST) begin
                abort = 1'b1;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end
`endif

        if (finish || abort) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            busy_d     = 1'b0;
            done_d     = finish;
            error_d    = abort;
            state_d    = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            crc_q      <= 16'hFFFF;
            rem_q      <= '0;
            is_data_q  <= 1'b0;
`ifdef USB_PKT_TX_TIMEOUT_EN
            to_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            crc_q      <= crc_d;
            rem_q      <= rem_d;
            is_data_q  <= is_data_d;
`ifdef USB_PKT_TX_TIMEOUT_EN
            to_q       <= to_d;
`endif
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_packet_tx.sv
`default_nettype none
// ============================================================================
// tb_usb_packet_tx : directed self-checking bench for usb_packet_tx
// Revision 1.0     : initial release
// ============================================================================
module tb_usb_packet_tx;

    localparam int TO_CYC = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] pid;
    logic [3:0] len;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;

    int total = 0;
    int bad   = 0;

    usb_packet_tx #(.MAX_LEN(8), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pid      (pid),
        .len      (len),
        .pl_data  (pl_data),
        .pl_valid (pl_valid),
        .pl_ready (pl_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Bit-serial USB CRC16 reference: feedback = crc[0] ^ data bit, LSB first
    function automatic logic [15:0] ref_crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = {1'b0, r[15:1]};
            if (fb) r = r ^ 16'hA001;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse tx_ready for one cycle; report the byte offered and whether pl_ready fired
    task automatic give_ready(output logic [7:0] b, output logic plr);
        b        = tx_data;
        tx_ready = 1'b1;
        #1;
        plr      = pl_ready;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        total++; if ({busy, done, error, pl_ready} !== 4'b0000) begin
            bad++; $display("FAIL rst_flags: got busy/done/error/pl_ready=%b want 0000", {busy, done, error, pl_ready});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_ack();
        logic [7:0] b;
        logic       plr;
        pid = 4'h2; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if ({tx_valid, busy, tx_data} !== {2'b11, 8'hD2}) begin
            bad++; $display("FAIL ack_pid: got valid=%b busy=%b data=%h want 1 1 d2", tx_valid, busy, tx_data);
        end
        give_ready(b, plr);
        total++; if (plr !== 1'b0) begin bad++; $display("FAIL ack_pl_ready: got %b want 0", plr); end
        total++; if ({tx_valid, done, busy, error} !== 4'b0100) begin
            bad++; $display("FAIL ack_done: got valid/done/busy/error=%b want 0100", {tx_valid, done, busy, error});
        end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL ack_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_zero_len();
        logic [7:0] b;
        logic       plr;
        pid = 4'h3; len = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (tx_data !== 8'hC3) begin bad++; $display("FAIL zl_pid: got %h want c3", tx_data); end
        give_ready(b, plr);
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL zl_crc_lo: got %h want 00", tx_data); end
        give_ready(b, plr);
        total++; if ({tx_valid, tx_data} !== {1'b1, 8'h00}) begin
            bad++; $display("FAIL zl_crc_hi: got valid=%b data=%h want 1 00", tx_valid, tx_data);
        end
        give_ready(b, plr);
        total++; if ({tx_valid, done} !== 2'b01) begin
            bad++; $display("FAIL zl_done: got valid=%b done=%b want 0 1", tx_valid, done);
        end
        tick();
    endtask

    task automatic test_data4();
        logic [7:0]  b;
        logic        plr;
        logic [15:0] crc;
        int          npl;
        crc = 16'hFFFF;
        npl = 0;
        pid = 4'hB; len = 4'd4; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (tx_data !== 8'h4B) begin bad++; $display("FAIL d4_pid: got %h want 4b", tx_data); end
        tick();
        total++; if ({tx_valid, tx_data} !== {1'b1, 8'h4B}) begin
            bad++; $display("FAIL d4_hold: got valid=%b data=%h want 1 4b", tx_valid, tx_data);
        end
        pl_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pl_data = 8'(i);
            give_ready(b, plr);
            if (plr) npl++;
            crc = ref_crc_step(crc, 8'(i));
            total++; if (tx_data !== 8'(i)) begin bad++; $display("FAIL d4_payload%0d: got %h want %h", i, tx_data, 8'(i)); end
        end
        // payload still valid here: the block must not pull any more bytes
        pl_data = 8'hEE;
        give_ready(b, plr);
        if (plr) npl++;
        total++; if (tx_data !== ~crc[7:0]) begin bad++; $display("FAIL d4_crc_lo: got %h want %h", tx_data, ~crc[7:0]); end
        give_ready(b, plr);
        if (plr) npl++;
        total++; if (tx_data !== ~crc[15:8]) begin bad++; $display("FAIL d4_crc_hi: got %h want %h", tx_data, ~crc[15:8]); end
        give_ready(b, plr);
        if (plr) npl++;
        total++; if ({tx_valid, done, busy} !== 3'b010) begin
            bad++; $display("FAIL d4_done: got valid/done/busy=%b want 010", {tx_valid, done, busy});
        end
        total++; if (npl !== 4) begin bad++; $display("FAIL d4_pl_ready_count: got %0d want 4", npl); end
        pl_valid = 1'b0;
        tick();
    endtask

    task automatic test_underrun();
        logic [7:0] b;
        logic       plr;
        pid = 4'h3; len = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        pl_valid = 1'b1; pl_data = 8'hAA;
        give_ready(b, plr);
        total++; if (tx_data !== 8'hAA) begin bad++; $display("FAIL ur_byte1: got %h want aa", tx_data); end
        pl_valid = 1'b0;
        give_ready(b, plr);
        total++; if (plr !== 1'b0) begin bad++; $display("FAIL ur_pl_ready: got %b want 0", plr); end
        total++; if ({tx_valid, error, done, busy} !== 4'b0100) begin
            bad++; $display("FAIL ur_abort: got valid/error/done/busy=%b want 0100", {tx_valid, error, done, busy});
        end
        pid = 4'h2; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if ({tx_valid, busy, tx_data, error} !== {2'b11, 8'hD2, 1'b0}) begin
            bad++; $display("FAIL ur_restart: got valid=%b busy=%b data=%h error=%b want 1 1 d2 0", tx_valid, busy, tx_data, error);
        end
        give_ready(b, plr);
        tick();
    endtask

    task automatic test_reject();
        pid = 4'h3; len = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if ({error, tx_valid, busy, done} !== 4'b1000) begin
            bad++; $display("FAIL rej_error: got error/valid/busy/done=%b want 1000", {error, tx_valid, busy, done});
        end
        tick();
        total++; if ({error, tx_valid} !== 2'b00) begin
            bad++; $display("FAIL rej_after: got error=%b valid=%b want 0 0", error, tx_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic       plr;
        pid = 4'h2; start = 1'b1;
        tick();
        pid = 4'h3; len = 4'd0;
        tick();
        start = 1'b0;
        total++; if ({tx_data, error} !== {8'hD2, 1'b0}) begin
            bad++; $display("FAIL b2b_ignore: got data=%h error=%b want d2 0", tx_data, error);
        end
        give_ready(b, plr);
        pid = 4'h3; len = 4'd0; start = 1'b1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", done); end
        tick();
        start = 1'b0;
        total++; if ({tx_valid, busy, tx_data} !== {2'b11, 8'hC3}) begin
            bad++; $display("FAIL b2b_next: got valid=%b busy=%b data=%h want 1 1 c3", tx_valid, busy, tx_data);
        end
        give_ready(b, plr);
        give_ready(b, plr);
        give_ready(b, plr);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done2: got %b want 1", done); end
        tick();
    endtask

    task automatic test_async_reset();
        logic [7:0] b;
        logic       plr;
        pid = 4'h3; len = 4'd4; start = 1'b1;
        tick();
        start = 1'b0;
        pl_valid = 1'b1; pl_data = 8'h55;
        give_ready(b, plr);
        pl_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        total++; if ({tx_valid, busy, tx_data} !== {2'b00, 8'h00}) begin
            bad++; $display("FAIL arst: got valid=%b busy=%b data=%h want 0 0 00", tx_valid, busy, tx_data);
        end
        tick();
        reset = 1'b1;
        tick();
        total++; if ({tx_valid, busy, done, error} !== 4'b0000) begin
            bad++; $display("FAIL arst_release: got valid/busy/done/error=%b want 0000", {tx_valid, busy, done, error});
        end
    endtask

`ifdef USB_PKT_TX_TIMEOUT_EN
    task automatic test_timeout();
        int cnt;
        cnt = 0;
        pid = 4'h2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2 * TO_CYC && !error; k++) begin
            tick();
            cnt++;
        end
        total++; if (error !== 1'b1) begin bad++; $display("FAIL to_error: got %b want 1 (no abort within bound)", error); end
        total++; if (cnt !== TO_CYC) begin bad++; $display("FAIL to_latency: got %0d want %0d", cnt, TO_CYC); end
        total++; if ({tx_valid, busy, done} !== 3'b000) begin
            bad++; $display("FAIL to_state: got valid/busy/done=%b want 000", {tx_valid, busy, done});
        end
        tick();
    endtask
`else
    task automatic test_timeout();
        logic [7:0] b;
        logic       plr;
        logic       saw_err;
        logic       lost_valid;
        saw_err = 1'b0; lost_valid = 1'b0;
        pid = 4'h2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < TO_CYC + 100; k++) begin
            tick();
            if (error) saw_err = 1'b1;
            if (!tx_valid) lost_valid = 1'b1;
        end
        total++; if ({saw_err, lost_valid} !== 2'b00) begin
            bad++; $display("FAIL nto_wait: got error_seen=%b valid_lost=%b want 0 0", saw_err, lost_valid);
        end
        give_ready(b, plr);
        total++; if ({done, tx_valid} !== 2'b10) begin
            bad++; $display("FAIL nto_done: got done=%b valid=%b want 1 0", done, tx_valid);
        end
        tick();
    endtask
`endif

    initial begin
        reset = 1'b0; start = 1'b0; pid = 4'h0; len = 4'd0;
        pl_data = 8'h00; pl_valid = 1'b0; tx_ready = 1'b0;
        test_reset();
        test_ack();
        test_zero_len();
        test_data4();
        test_underrun();
        test_reject();
        test_back_to_back();
        test_async_reset();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
